mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 24 ++
 rtl/mem_resp_delay.sv | 32 +++
 rtl/mem_responder.sv | 105 ++++++++++
 tb/tb_mem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the backing-memory responder: interface widths, default
// timing parameters and the stall-LFSR constants used when MEM_RESP_STALL_EN is defined.
package mem_responder_pkg;

   localparam int unsigned MEM_ADDR_W = 32;
   localparam int unsigned MEM_DATA_W = 32;

   localparam int unsigned DEF_LATENCY         = 4;
   localparam int unsigned DEF_MAX_OUTSTANDING = 4;

   // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   typedef struct packed {
      logic                  valid;
      logic [MEM_DATA_W-1:0] data;
   } resp_t;

   function automatic logic lfsr_feedback(input logic [7:0] state);
      return ^(state & LFSR_TAPS);
   endfunction

endpackage

// File: rtl/mem_resp_delay.sv
// Fixed-latency read-response pipeline: LATENCY stages of {valid, data}, flushed by reset.
module mem_resp_delay
   import mem_responder_pkg::*;
#(
   parameter int unsigned LATENCY = DEF_LATENCY
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic [MEM_DATA_W-1:0] i_data,
   output logic                  o_valid,
   output logic [MEM_DATA_W-1:0] o_data
);

   resp_t [LATENCY-1:0] pipe_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0].valid <= i_valid;
         pipe_q[0].data  <= i_data;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign o_valid = pipe_q[LATENCY-1].valid;
   assign o_data  = o_valid ? pipe_q[LATENCY-1].data : '0;

endmodule

// File: rtl/mem_responder.sv
// Word-granular memory responder: posted writes, in-order fixed-latency reads, ready-based
// backpressure. Define MEM_RESP_STALL_EN to add ~25% pseudo-random LFSR backpressure.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W          = 12,
   parameter int unsigned LATENCY         = DEF_LATENCY,
   parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   output logic                  o_mem_ready,
   input  logic [MEM_ADDR_W-1:0] i_mem_addr,
   input  logic                  i_mem_ren,
   input  logic                  i_mem_wen,
   input  logic [MEM_DATA_W-1:0] i_mem_wdata,
   output logic [MEM_DATA_W-1:0] o_mem_rdata,
   output logic                  o_mem_valid,
   output logic                  o_err
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   logic [MEM_DATA_W-1:0] mem_q [2**ADDR_W];

   logic              rst_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              err_q;
   logic              stall;
   logic              accept, rd_accept, wr_accept;
   logic [ADDR_W-1:0] word_idx;
   logic              unused_addr_bits;

   assign word_idx         = i_mem_addr[ADDR_W+1:2];
   assign unused_addr_bits = ^{i_mem_addr[MEM_ADDR_W-1:ADDR_W+2], i_mem_addr[1:0]};

`ifdef MEM_RESP_STALL_EN
   logic [7:0] lfsr_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_feedback(lfsr_q)};
      end
   end

   assign stall = (lfsr_q[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // Ready comes from registered state (plus reset) only, never from ren/wen.
   assign o_mem_ready = ~i_rst & ~rst_q & (count_q < MAX_CNT) & ~stall;

   assign accept    = (i_mem_ren | i_mem_wen) & o_mem_ready;
   assign wr_accept = accept & i_mem_wen;
   // A simultaneous ren/wen performs only the write.
   assign rd_accept = accept & i_mem_ren & ~i_mem_wen;

   always_comb begin
      count_d = count_q;
      if (rd_accept && !o_mem_valid) begin
         count_d = count_q + 1'b1;
      end else if (!rd_accept && o_mem_valid) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rst_q   <= 1'b1;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         rst_q   <= 1'b0;
         count_q <= count_d;
         if (accept && i_mem_ren && i_mem_wen) begin
            err_q <= 1'b1;
         end
      end
   end

   // Array contents deliberately survive reset.
   always_ff @(posedge i_clk) begin
      if (wr_accept) begin
         mem_q[word_idx] <= i_mem_wdata;
      end
   end

   mem_resp_delay #(
      .LATENCY (LATENCY)
   ) u_delay (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (rd_accept),
      .i_data  (mem_q[word_idx]),
      .o_valid (o_mem_valid),
      .o_data  (o_mem_rdata)
   );

   assign o_err = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based reference model.
module tb_mem_responder;

   localparam int unsigned AW   = 10;
   localparam int unsigned LAT  = 4;
   localparam int unsigned MAXO = 4;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        o_mem_ready;
   logic [31:0] i_mem_addr = '0;
   logic        i_mem_ren = 1'b0;
   logic        i_mem_wen = 1'b0;
   logic [31:0] i_mem_wdata = '0;
   logic [31:0] o_mem_rdata;
   logic        o_mem_valid;
   logic        o_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   mem_responder #(
      .ADDR_W          (AW),
      .LATENCY         (LAT),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .o_mem_ready (o_mem_ready),
      .i_mem_addr  (i_mem_addr),
      .i_mem_ren   (i_mem_ren),
      .i_mem_wen   (i_mem_wen),
      .i_mem_wdata (i_mem_wdata),
      .o_mem_rdata (o_mem_rdata),
      .o_mem_valid (o_mem_valid),
      .o_err       (o_err)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: pending reads carry the cycle in which their data must appear.
   typedef struct {
      int          due;
      logic [31:0] data;
      bit          known;
   } pend_t;

   pend_t       pend_q[$];
   logic [31:0] mem_m [int];
   bit          rst_q_m = 1'b1;
   bit          err_m = 1'b0;

   always @(negedge i_clk) begin : monitor
      bit exp_ready;
      bit exp_valid;
      int idx;
      exp_ready = !i_rst && !rst_q_m && (pend_q.size() < MAXO);
      exp_valid = (pend_q.size() > 0) && (pend_q[0].due == cyc);
      check("mon_ready", {31'b0, o_mem_ready}, {31'b0, exp_ready});
      check("mon_valid", {31'b0, o_mem_valid}, {31'b0, exp_valid});
      check("mon_err", {31'b0, o_err}, {31'b0, err_m});
      if (exp_valid) begin
         if (pend_q[0].known) check("mon_rdata", o_mem_rdata, pend_q[0].data);
         void'(pend_q.pop_front());
      end else begin
         check("mon_rdata_idle", o_mem_rdata, 32'h0);
      end
      // Inputs now on the bus are sampled at the coming edge.
      if (i_rst) begin
         pend_q.delete();
         err_m   = 1'b0;
         rst_q_m = 1'b1;
      end else begin
         rst_q_m = 1'b0;
         if (exp_ready && (i_mem_ren || i_mem_wen)) begin
            idx = int'((i_mem_addr >> 2) % (32'd1 << AW));
            if (i_mem_wen) begin
               mem_m[idx] = i_mem_wdata;
               if (i_mem_ren) err_m = 1'b1;
            end else begin
               pend_q.push_back('{due: cyc + LAT,
                                  data: mem_m.exists(idx) ? mem_m[idx] : 32'h0,
                                  known: mem_m.exists(idx)});
            end
         end
      end
   end

   task automatic drive(input logic rst, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
      @(posedge i_clk);
      #1;
      i_rst       = rst;
      i_mem_ren   = ren;
      i_mem_wen   = wen;
      i_mem_addr  = addr;
      i_mem_wdata = wdata;
   endtask

   // Call right after the read's accept edge; expects the pulse LAT-1 negedges later.
   task automatic wait_valid(input string name, input logic [31:0] exp);
      bit seen = 1'b0;
      for (int n = 0; n < int'(LAT) + 6 && !seen; n++) begin
         @(negedge i_clk);
         if (o_mem_valid) begin
            seen = 1'b1;
            check({name, "_latency"}, 32'(n), 32'(LAT - 1));
            check({name, "_data"}, o_mem_rdata, exp);
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s: no valid pulse within bound, expected data %h", name, exp);
      end
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } vec_t;

   vec_t vec [8];

   initial begin
      int          r;
      int unsigned idx;
      logic        ren, wen;
      logic [31:0] a;

      vec[0] = '{wr: 1'b1, addr: 32'h0000_0010, data: 32'hDEAD_BEEF};
      vec[1] = '{wr: 1'b0, addr: 32'h0000_0010, data: 32'hDEAD_BEEF};
      vec[2] = '{wr: 1'b1, addr: 32'h0000_1000, data: 32'h1111_1111};
      vec[3] = '{wr: 1'b0, addr: 32'h0000_0000, data: 32'h1111_1111};
      vec[4] = '{wr: 1'b1, addr: 32'h0000_0FFC, data: 32'hCAFE_F00D};
      vec[5] = '{wr: 1'b0, addr: 32'hFFFF_FFFC, data: 32'hCAFE_F00D};
      vec[6] = '{wr: 1'b1, addr: 32'h0000_0003, data: 32'h1234_5678};
      vec[7] = '{wr: 1'b0, addr: 32'h0000_1001, data: 32'h1234_5678};

      // Reset held: outputs quiet.
      repeat (3) begin
         @(negedge i_clk);
         check("rst_ready", {31'b0, o_mem_ready}, 32'h0);
         check("rst_valid", {31'b0, o_mem_valid}, 32'h0);
         check("rst_rdata", o_mem_rdata, 32'h0);
         check("rst_err", {31'b0, o_err}, 32'h0);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge i_clk);
      check("release_ready", {31'b0, o_mem_ready}, 32'h1);

      // Vector table: write-then-read, aliasing, top word, ignored byte bits.
      for (int i = 0; i < 8; i++) begin
         if (vec[i].wr) begin
            drive(1'b0, 1'b0, 1'b1, vec[i].addr, vec[i].data);
         end else begin
            drive(1'b0, 1'b1, 1'b0, vec[i].addr, 32'h0);
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            wait_valid($sformatf("vec%0d", i), vec[i].data);
         end
      end

      // Burst of four reads fills the outstanding limit; fifth request is ignored.
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'(i + 1));
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
      @(negedge i_clk);
      check("burst_ready_low", {31'b0, o_mem_ready}, 32'h0);
      check("burst_valid0", {31'b0, o_mem_valid}, 32'h1);
      check("burst_rdata0", o_mem_rdata, 32'h1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 1; i < 4; i++) begin
         @(negedge i_clk);
         check("burst_ready", {31'b0, o_mem_ready}, 32'h1);
         check("burst_valid", {31'b0, o_mem_valid}, 32'h1);
         check("burst_rdata", o_mem_rdata, 32'(i + 1));
      end
      repeat (4) @(negedge i_clk);

      // Illegal simultaneous ren/wen: write lands, read dropped, sticky error.
      drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h5A5A_5A5A);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (6) begin
         @(negedge i_clk);
         check("illegal_err", {31'b0, o_err}, 32'h1);
         check("illegal_no_valid", {31'b0, o_mem_valid}, 32'h0);
      end
      drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      wait_valid("illegal_readback", 32'h5A5A_5A5A);
      check("illegal_err_sticky", {31'b0, o_err}, 32'h1);

      // Reset with two reads in flight.
      drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h104, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (20) begin
         @(negedge i_clk);
         check("flush_no_valid", {31'b0, o_mem_valid}, 32'h0);
         check("flush_rdata", o_mem_rdata, 32'h0);
      end
      check("flush_ready", {31'b0, o_mem_ready}, 32'h1);
      check("flush_err_cleared", {31'b0, o_err}, 32'h0);

      // Randomized traffic over 16 words with random aliasing and byte-offset bits.
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b1, 32'(i * 4), $urandom);
      for (int n = 0; n < 400; n++) begin
         r   = int'($urandom_range(0, 99));
         idx = $urandom_range(0, 15);
         a   = ($urandom & 32'hFFFF_F003) | (idx << 2);
         ren = (r < 50) || (r >= 97);
         wen = (r >= 50 && r < 80) || (r >= 97);
         drive(1'b0, ren, wen, a, $urandom);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (LAT + 6) @(negedge i_clk);
      check("drain_pending", 32'(pend_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
